score_keeper: RTL and testbench

Per-player score accumulator and display feed for the two-player note highway. It takes single-cycle hit/miss pulses from the note-judging logic and keeps a saturating score, streak and multiplier for each player. Once per frame it converts both scores to three BCD digits with a sequential double-dabble converter. It holds those digits stable for the on-screen score renderer, which turns each digit into a font-ROM character address.

---
 rtl/rb_score_pkg.sv | 36 +++
 rtl/bcd_dd10.sv | 37 +++
 rtl/score_keeper.sv | 167 ++++++++++++++++
 tb/tb_score_keeper.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_score_pkg.sv
// Shared types, defaults and the double-dabble nibble adjust for the
// score keeper.
package rb_score_pkg;

    typedef logic [9:0]  score_t;
    typedef logic [11:0] bcd3_t;
    typedef logic [2:0]  mult_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_t;

    localparam int DEF_HIT_POINTS  = 1;
    localparam int DEF_STREAK_STEP = 10;
    localparam int DEF_MAX_MULT    = 4;
    localparam int DEF_MAX_SCORE   = 999;

    // One double-dabble pass per bit of the 10-bit score.
    localparam int CONV_ITERS = 10;

    // Add 3 to every BCD nibble that is 5 or more, so that the following
    // left shift carries correctly into the next decimal digit.
    function automatic bcd3_t dd_adjust(input bcd3_t b);
        bcd3_t r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_dd10.sv
// Iteration-stepped double-dabble converter: load a 10-bit value, then
// apply one adjust-and-shift per step; after ten steps the upper twelve
// bits of the shift register hold {hundreds, tens, ones}.
module bcd_dd10
    import rb_score_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset_n,
    input  logic   load,
    input  logic   step,
    input  score_t bin,
    output bcd3_t  bcd
);

    // {bcd digits, remaining binary bits}
    logic [21:0] sr;
    logic [21:0] adjusted;

    // Adjust the digit field ahead of the shift.
    always_comb begin
        adjusted = {dd_adjust(sr[21:10]), sr[9:0]};
    end

    // Load takes priority over step; the register simply holds otherwise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= {12'h000, bin};
        end else if (step) begin
            sr <= {adjusted[20:0], 1'b0};
        end
    end

    assign bcd = sr[21:10];

endmodule

// File: rtl/score_keeper.sv
// Two-player score accumulator with streak-driven multiplier, plus a
// once-per-frame BCD conversion that feeds the on-screen score renderer.
module score_keeper
    import rb_score_pkg::*;
#(
    parameter int HIT_POINTS  = DEF_HIT_POINTS,
    parameter int STREAK_STEP = DEF_STREAK_STEP,
    parameter int MAX_MULT    = DEF_MAX_MULT,
    parameter int MAX_SCORE   = DEF_MAX_SCORE
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        clear,
    input  logic        p1_hit,
    input  logic        p2_hit,
    input  logic        p1_miss,
    input  logic        p2_miss,
    output logic [11:0] p1_digits,
    output logic [11:0] p2_digits,
    output logic [2:0]  p1_mult,
    output logic [2:0]  p2_mult,
    output logic        busy
);

    logic [2:0]  frame_sync;
    logic        frame_rise;
    logic [1:0]  hit;
    logic [1:0]  miss;
    score_t      score      [2];
    logic [7:0]  streak     [2];
    mult_t       mult       [2];
    logic [10:0] sum        [2];
    score_t      next_score [2];

    conv_state_t state;
    logic [3:0]  iter;
    logic        snap;
    logic        shift;
    bcd3_t       p1_bcd;
    bcd3_t       p2_bcd;

    assign hit  = {p2_hit, p1_hit};
    assign miss = {p2_miss, p1_miss};

    // Two flops resynchronise frame_clk, the third remembers the last level.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync <= 3'b000;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
        end
    end

    assign frame_rise = frame_sync[1] & ~frame_sync[2];

    // Score after a hit, summed 11 bits wide so the clamp sees any overflow.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sum[i]        = {1'b0, score[i]} + 11'(HIT_POINTS) * {8'h00, mult[i]};
            next_score[i] = (sum[i] > 11'(MAX_SCORE)) ? score_t'(MAX_SCORE) : sum[i][9:0];
        end
    end

    // Per-player state: clear beats miss, miss beats hit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 2; i++) begin
                score[i]  <= '0;
                streak[i] <= '0;
                mult[i]   <= mult_t'(1);
            end
        end else if (clear) begin
            for (int i = 0; i < 2; i++) begin
                score[i]  <= '0;
                streak[i] <= '0;
                mult[i]   <= mult_t'(1);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (miss[i]) begin
                    streak[i] <= '0;
                    mult[i]   <= mult_t'(1);
                end else if (hit[i]) begin
                    score[i] <= next_score[i];
                    if (streak[i] == 8'(STREAK_STEP - 1)) begin
                        streak[i] <= '0;
                        if (mult[i] != mult_t'(MAX_MULT)) begin
                            mult[i] <= mult[i] + mult_t'(1);
                        end
                    end else begin
                        streak[i] <= streak[i] + 8'd1;
                    end
                end
            end
        end
    end

    assign p1_mult = mult[0];
    assign p2_mult = mult[1];

    // Converter controls: snapshot on an accepted rise, shift while converting.
    assign snap  = (state == IDLE) && frame_rise && !clear;
    assign shift = (state == CONV) && !clear;

    bcd_dd10 u_p1_conv (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (snap),
        .step    (shift),
        .bin     (score[0]),
        .bcd     (p1_bcd)
    );

    bcd_dd10 u_p2_conv (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (snap),
        .step    (shift),
        .bin     (score[1]),
        .bcd     (p2_bcd)
    );

    // Conversion sequencer; digits only move at LOAD or on clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            iter      <= 4'd0;
            busy      <= 1'b0;
            p1_digits <= 12'h000;
            p2_digits <= 12'h000;
        end else if (clear) begin
            state     <= IDLE;
            iter      <= 4'd0;
            busy      <= 1'b0;
            p1_digits <= 12'h000;
            p2_digits <= 12'h000;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        state <= CONV;
                        iter  <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                CONV: begin
                    iter <= iter + 4'd1;
                    if (iter == 4'(CONV_ITERS - 1)) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    p1_digits <= p1_bcd;
                    p2_digits <= p2_bcd;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: random and directed hit/miss traffic against a
// plain-arithmetic reference model, frame results checked through an
// expected-value queue drained by an independent monitor.
module tb_score_keeper;

    localparam int HP   = 1;
    localparam int STEP = 10;
    localparam int MAXM = 4;
    localparam int MAXS = 999;

    logic        clk;
    logic        Reset_n;
    logic        frame_clk;
    logic        clear;
    logic        p1_hit, p2_hit, p1_miss, p2_miss;
    logic [11:0] p1_digits, p2_digits;
    logic [2:0]  p1_mult, p2_mult;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: {p1_digits, p2_digits} expected at each completed frame.
    logic [23:0] exp_q[$];
    logic [11:0] last_p1, last_p2;

    // Reference model state.
    int m_score[2];
    int m_streak[2];
    int m_mult[2];

    score_keeper dut (
        .Clk       (clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .clear     (clear),
        .p1_hit    (p1_hit),
        .p2_hit    (p2_hit),
        .p1_miss   (p1_miss),
        .p2_miss   (p2_miss),
        .p1_digits (p1_digits),
        .p2_digits (p2_digits),
        .p1_mult   (p1_mult),
        .p2_mult   (p2_mult),
        .busy      (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_score[i]  = 0;
            m_streak[i] = 0;
            m_mult[i]   = 1;
        end
    endfunction

    function automatic void model_player(input int p, input logic h, input logic m);
        if (m) begin
            m_streak[p] = 0;
            m_mult[p]   = 1;
        end else if (h) begin
            m_score[p] = m_score[p] + HP * m_mult[p];
            if (m_score[p] > MAXS) m_score[p] = MAXS;
            m_streak[p]++;
            if (m_streak[p] == STEP) begin
                m_streak[p] = 0;
                if (m_mult[p] < MAXM) m_mult[p]++;
            end
        end
    endfunction

    // Driver: present one cycle of events, sampled at the next rising edge.
    task automatic cycle(input logic h1, input logic m1, input logic h2,
                         input logic m2, input logic clr);
        p1_hit  = h1;
        p1_miss = m1;
        p2_hit  = h2;
        p2_miss = m2;
        clear   = clr;
        if (clr) begin
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                exp_q.push_back(24'h000000);
            end
            last_p1 = 12'h000;
            last_p2 = 12'h000;
        end
        @(posedge clk);
        #2;
        p1_hit  = 1'b0;
        p1_miss = 1'b0;
        p2_hit  = 1'b0;
        p2_miss = 1'b0;
        clear   = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            model_player(0, h1, m1);
            model_player(1, h2, m2);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_cycle(input int pct);
        logic h1, m1, h2, m2;
        h1 = ($urandom_range(0, 99) < pct);
        m1 = ($urandom_range(0, 99) < pct / 6);
        h2 = ($urandom_range(0, 99) < pct);
        m2 = ($urandom_range(0, 99) < pct / 6);
        cycle(h1, m1, h2, m2, 1'b0);
    endtask

    task automatic push_expected();
        last_p1 = to_bcd(m_score[0]);
        last_p2 = to_bcd(m_score[1]);
        exp_q.push_back({last_p1, last_p2});
    endtask

    // One frame strobe; events sampled before the snapshot edge are counted.
    task automatic frame(input int pct);
        int waited;
        frame_clk = 1'b1;
        rand_cycle(pct);
        rand_cycle(pct);
        push_expected();
        rand_cycle(pct);
        rand_cycle(pct);
        frame_clk = 1'b0;
        waited = 0;
        while (busy && waited < 30) begin
            rand_cycle(pct);
            waited++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_timeout: busy still %0b after %0d cycles", busy, waited);
        end
        idle(3);
    endtask

    task automatic check_mults(input string tag);
        check({tag, "_p1_mult"}, 32'(p1_mult), 32'(m_mult[0]));
        check({tag, "_p2_mult"}, 32'(p2_mult), 32'(m_mult[1]));
    endtask

    // Monitor: every completed conversion must match the oldest expectation.
    initial begin
        logic        prev_busy;
        logic [23:0] exp_v;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!Reset_n) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_load: digits %h/%h with nothing pending", p1_digits, p2_digits);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("frame_digits", {8'h00, p1_digits, p2_digits}, {8'h00, exp_v});
                    end
                end
                prev_busy = busy;
            end
        end
    end

    // Exact frame-to-digits timing, with a second rise during conversion.
    task automatic latency_test();
        logic [23:0] old_d, new_d;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        old_d = {last_p1, last_p2};
        new_d = {to_bcd(m_score[0]), to_bcd(m_score[1])};
        push_expected();
        frame_clk = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            check("lat_busy", 32'(busy), 32'((k >= 2 && k <= 12) ? 1 : 0));
            check("lat_digits", {8'h00, p1_digits, p2_digits}, {8'h00, (k >= 13) ? new_d : old_d});
            if (k == 2) frame_clk = 1'b0;
            if (k == 5) frame_clk = 1'b1;
            if (k == 8) frame_clk = 1'b0;
        end
        idle(3);
        check("lat_no_second_conv", 32'(busy), 32'd0);
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        clear     = 1'b0;
        p1_hit    = 1'b0;
        p2_hit    = 1'b0;
        p1_miss   = 1'b0;
        p2_miss   = 1'b0;
        last_p1   = 12'h000;
        last_p2   = 12'h000;
        model_reset();

        repeat (3) @(posedge clk);
        #2;
        check("rst_p1_digits", 32'(p1_digits), 32'h000);
        check("rst_p2_digits", 32'(p2_digits), 32'h000);
        check("rst_busy", 32'(busy), 32'd0);
        check_mults("rst");
        Reset_n = 1'b1;
        idle(2);

        // Multiplier step after twelve hits.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(0);
        check_mults("mstep");

        // Miss drops multiplier back to 1.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_mults("pre_miss");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(0);
        check_mults("miss");

        // Hit and miss together on p1, hit on p2.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        frame(0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_mults("simul");

        latency_test();

        // Random traffic, including events during conversion.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) rand_cycle(55);
            frame(50);
            check_mults("rand");
        end

        // Saturation at 999 and staying there.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
        frame(0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(0);
        check_mults("sat");

        // Clear during conversion.
        frame_clk = 1'b1;
        idle(2);
        push_expected();
        idle(3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_digits", {8'h00, p1_digits, p2_digits}, 32'h0);
        check_mults("clr");
        frame_clk = 1'b0;
        idle(4);
        frame(0);

        // Reset during conversion.
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(0);
        frame_clk = 1'b1;
        idle(5);
        Reset_n = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        last_p1 = 12'h000;
        last_p2 = 12'h000;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_digits", {8'h00, p1_digits, p2_digits}, 32'h0);
        check_mults("arst");
        frame_clk = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        Reset_n = 1'b1;
        idle(3);
        frame(0);

        idle(5);
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
